// File: rtl/disparity_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : disparity_frame_sync
// Description : Aligns the census stereo core's disparity stream to raster
//               coordinates, zeroes incomplete-window borders, tags SOF/EOL/EOF
//               and buffers results in a show-ahead valid/ready FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module disparity_frame_sync #(
  parameter int LINE_LENGTH  = 320,
  parameter int NUM_LINES    = 240,
  parameter int DISP_W       = 7,
  parameter int DISPARITY    = 80,
  parameter int WIN_WIDTH    = 11,
  parameter int WIN_HEIGHT   = 11,
  parameter int PIPE_LATENCY = 12,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_start,
  input  logic [DISP_W-1:0] disp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] disp_out,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              overflow,
  output logic              busy
);

  localparam int X_W     = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int Y_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int LAT_W   = $clog2(PIPE_LATENCY + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DISP_W + 3;

  // First column/row where the census window and disparity search are complete
  localparam int X_MIN = WIN_WIDTH + DISPARITY - 2;
  localparam int Y_MIN = WIN_HEIGHT - 1;

  localparam logic [X_W-1:0]   X_LAST   = X_W'(LINE_LENGTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(NUM_LINES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_next;
  logic [X_W-1:0]     x, x_next;
  logic [Y_W-1:0]     y, y_next;
  logic               capture;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, pop, push, drop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic [DISP_W-1:0]  disp_masked;
  logic               tag_sof, tag_eol, tag_eof;

  // Next-state, raster counters and capture strobe; everything gated by en
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    x_next       = x;
    y_next       = y;
    capture      = 1'b0;
    if (en) begin
      if (frame_start) begin
        // Restart from any state; the FIFO keeps whatever it already holds
        state_next   = FILL;
        lat_cnt_next = LAT_W'(1);
        x_next       = '0;
        y_next       = '0;
      end else begin
        case (state)
          IDLE: ;
          FILL: begin
            if (lat_cnt == LAT_LAST) begin
              capture    = 1'b1;
              state_next = ACTIVE;
            end else begin
              lat_cnt_next = lat_cnt + LAT_W'(1);
            end
          end
          ACTIVE:  capture    = 1'b1;
          default: state_next = IDLE;
        endcase
        // Raster advances on every capture, even when the FIFO drops it
        if (capture) begin
          if (x == X_LAST) begin
            x_next = '0;
            if (y == Y_LAST) begin
              y_next     = '0;
              state_next = IDLE;
            end else begin
              y_next = y + Y_W'(1);
            end
          end else begin
            x_next = x + X_W'(1);
          end
        end
      end
    end
  end

  // FSM and raster counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      x       <= '0;
      y       <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      x       <= x_next;
      y       <= y_next;
    end
  end

  // Border masking and frame markers for the pixel being captured
  always_comb begin
    disp_masked = ((int'(x) >= X_MIN) && (int'(y) >= Y_MIN)) ? disp_in : '0;
    tag_sof     = (x == '0) && (y == '0);
    tag_eol     = (x == X_LAST);
    tag_eof     = tag_eol && (y == Y_LAST);
    push_data   = {disp_masked, tag_sof, tag_eol, tag_eof};
  end

  // FIFO control: a pop frees the slot so a push into a full FIFO still lands
  always_comb begin
    full = (count == CNT_FULL);
    pop  = out_valid && out_ready;
    push = capture && (!full || pop);
    drop = capture && full && !pop;
  end

  // FIFO storage; contents need no reset because the count gates the outputs
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (en && frame_start) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Show-ahead head outputs, forced to zero while the FIFO is empty
  always_comb begin
    out_valid = (count != '0);
    head      = out_valid ? mem[rd_ptr] : '0;
    disp_out  = head[ENTRY_W-1:3];
    out_sof   = head[2];
    out_eol   = head[1];
    out_eof   = head[0];
    busy      = (state != IDLE);
  end

endmodule
`default_nettype wire
